// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - Memory access encodings shared by the EX/MEM register and load/store datapaths
package mem_pkg;

    typedef enum logic [2:0] {
        W_B  = 3'b000,
        W_H  = 3'b001,
        W_W  = 3'b010,
        W_BU = 3'b100,
        W_HU = 3'b101
    } width_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_FP   = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_e;

    // Unknown funct3 encodings are reported as misaligned so they never reach memory.
    function automatic logic width_misaligned(input logic [2:0] width, input logic [1:0] lsb);
        case (width)
            W_B, W_BU: return 1'b0;
            W_H, W_HU: return lsb[0];
            W_W:       return lsb != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// rtl/mem_align_check.sv - Natural-alignment check for a load or store effective address
module mem_align_check
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic            read,
    input  logic            write,
    input  logic [2:0]      load_width,
    input  logic [2:0]      store_width,
    output logic            misaligned
);

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[XLEN-1:2];

    // A store takes precedence when both controls are set.
    always_comb begin
        misaligned = 1'b0;
        if (write) begin
            misaligned = width_misaligned(store_width, addr[1:0]);
        end else if (read) begin
            misaligned = width_misaligned(load_width, addr[1:0]);
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with alignment squash, fault capture and counter
module ex_mem_pipe
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [2:0]       ex_load_width,
    input  logic [2:0]       ex_store_width,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_store_data,
    input  logic [XLEN-1:0]  ex_fp_result,
    input  logic [4:0]       ex_rd,
    input  logic             ex_werf,
    input  logic             ex_wefrf,
    input  logic [1:0]       ex_wb_sel,
    output logic             mem_valid,
    output logic             mem_read,
    output logic             mem_write,
    output logic [XLEN-1:0]  mem_address,
    output logic [XLEN-1:0]  store_data,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  fp_alu_result,
    output logic [2:0]       load_width,
    output logic [2:0]       store_width,
    output logic [4:0]       mem_rd,
    output logic             mem_werf,
    output logic             mem_wefrf,
    output logic [1:0]       mem_wb_sel,
    output logic             mem_load_pending,
    output logic             misaligned,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] misalign_count
);

    logic read_eff;
    logic chk_misaligned;
    logic ex_misaligned;

    assign read_eff = ex_mem_read & ~ex_mem_write;

    mem_align_check #(
        .XLEN(XLEN)
    ) u_align_check (
        .addr        (ex_alu_result),
        .read        (read_eff),
        .write       (ex_mem_write),
        .load_width  (ex_load_width),
        .store_width (ex_store_width),
        .misaligned  (chk_misaligned)
    );

    assign ex_misaligned = ALIGN_CHECK ? chk_misaligned : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            store_data     <= '0;
            alu_result     <= '0;
            fp_alu_result  <= '0;
            load_width     <= '0;
            store_width    <= '0;
            mem_rd         <= '0;
            mem_werf       <= 1'b0;
            mem_wefrf      <= 1'b0;
            mem_wb_sel     <= WB_ALU;
            misaligned     <= 1'b0;
            fault_addr     <= '0;
            misalign_count <= '0;
        end else if (flush) begin
            mem_valid  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_werf   <= 1'b0;
            mem_wefrf  <= 1'b0;
            misaligned <= 1'b0;
        end else if (!stall) begin
            // Data fields load unconditionally; they are ignored while the entry is a bubble.
            mem_address   <= ex_alu_result;
            alu_result    <= ex_alu_result;
            store_data    <= ex_store_data;
            fp_alu_result <= ex_fp_result;
            load_width    <= ex_load_width;
            store_width   <= ex_store_width;
            mem_rd        <= ex_rd;
            mem_wb_sel    <= ex_wb_sel;
            if (ex_valid) begin
                mem_valid  <= 1'b1;
                mem_read   <= read_eff & ~ex_misaligned;
                mem_write  <= ex_mem_write & ~ex_misaligned;
                mem_werf   <= ex_werf & ~ex_misaligned;
                mem_wefrf  <= ex_wefrf & ~ex_misaligned;
                misaligned <= ex_misaligned;
                if (ex_misaligned) begin
                    fault_addr <= ex_alu_result;
                    if (misalign_count != {CNT_W{1'b1}}) begin
                        misalign_count <= misalign_count + CNT_W'(1);
                    end
                end
            end else begin
                mem_valid  <= 1'b0;
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
                mem_werf   <= 1'b0;
                mem_wefrf  <= 1'b0;
                misaligned <= 1'b0;
            end
        end
    end

    assign mem_load_pending = mem_valid & mem_read;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - Self-checking bench for ex_mem_pipe, with and without alignment checking
module tb_ex_mem_pipe;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_load_width = '0;
    logic [2:0]  ex_store_width = '0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [31:0] ex_fp_result = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_werf = 1'b0;
    logic        ex_wefrf = 1'b0;
    logic [1:0]  ex_wb_sel = '0;

    // Index 0: alignment enforced; index 1: alignment checking disabled.
    logic [1:0]       o_valid, o_read, o_write, o_werf, o_wefrf, o_pend, o_misal;
    logic [1:0][31:0] o_addr, o_sdata, o_alu, o_fp, o_faddr;
    logic [1:0][2:0]  o_lw, o_sw;
    logic [1:0][4:0]  o_rd;
    logic [1:0][1:0]  o_wbsel;
    logic [1:0][7:0]  o_cnt;

    ex_mem_pipe #(.XLEN(XLEN), .ALIGN_CHECK(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_load_width(ex_load_width), .ex_store_width(ex_store_width),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_fp_result(ex_fp_result),
        .ex_rd(ex_rd), .ex_werf(ex_werf), .ex_wefrf(ex_wefrf), .ex_wb_sel(ex_wb_sel),
        .mem_valid(o_valid[0]), .mem_read(o_read[0]), .mem_write(o_write[0]),
        .mem_address(o_addr[0]), .store_data(o_sdata[0]), .alu_result(o_alu[0]),
        .fp_alu_result(o_fp[0]), .load_width(o_lw[0]), .store_width(o_sw[0]),
        .mem_rd(o_rd[0]), .mem_werf(o_werf[0]), .mem_wefrf(o_wefrf[0]), .mem_wb_sel(o_wbsel[0]),
        .mem_load_pending(o_pend[0]), .misaligned(o_misal[0]), .fault_addr(o_faddr[0]),
        .misalign_count(o_cnt[0])
    );

    ex_mem_pipe #(.XLEN(XLEN), .ALIGN_CHECK(1'b0), .CNT_W(CNT_W)) dut_nc (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_load_width(ex_load_width), .ex_store_width(ex_store_width),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_fp_result(ex_fp_result),
        .ex_rd(ex_rd), .ex_werf(ex_werf), .ex_wefrf(ex_wefrf), .ex_wb_sel(ex_wb_sel),
        .mem_valid(o_valid[1]), .mem_read(o_read[1]), .mem_write(o_write[1]),
        .mem_address(o_addr[1]), .store_data(o_sdata[1]), .alu_result(o_alu[1]),
        .fp_alu_result(o_fp[1]), .load_width(o_lw[1]), .store_width(o_sw[1]),
        .mem_rd(o_rd[1]), .mem_werf(o_werf[1]), .mem_wefrf(o_wefrf[1]), .mem_wb_sel(o_wbsel[1]),
        .mem_load_pending(o_pend[1]), .misaligned(o_misal[1]), .fault_addr(o_faddr[1]),
        .misalign_count(o_cnt[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          valid, rd, wr, werf, wefrf, misal;
        logic [31:0] addr, sdata, fp, faddr;
        logic [2:0]  lw, sw;
        logic [4:0]  rdst;
        logic [1:0]  wbsel;
        int          cnt;
    } exp_t;

    exp_t m[2];

    // Access size in bytes; 0 marks an encoding that is never legal.
    function automatic int access_bytes(input logic [2:0] w);
        case (w)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic exp_t model_step(input exp_t s, input bit check_on);
        exp_t n;
        bit   is_st, is_ld, bad;
        int   sz;
        n = s;
        if (rst) begin
            n = '{default: 0};
        end else if (flush || (!stall && !ex_valid)) begin
            n.valid = 0; n.rd = 0; n.wr = 0; n.werf = 0; n.wefrf = 0; n.misal = 0;
        end else if (!stall) begin
            is_st = ex_mem_write;
            is_ld = ex_mem_read && !ex_mem_write;
            sz    = access_bytes(is_st ? ex_store_width : ex_load_width);
            bad   = check_on && (is_st || is_ld) && (sz == 0 || (ex_alu_result % sz) != 0);
            n.valid = 1;
            n.rd    = is_ld && !bad;
            n.wr    = is_st && !bad;
            n.werf  = ex_werf && !bad;
            n.wefrf = ex_wefrf && !bad;
            n.misal = bad;
            n.addr  = ex_alu_result;
            n.sdata = ex_store_data;
            n.fp    = ex_fp_result;
            n.lw    = ex_load_width;
            n.sw    = ex_store_width;
            n.rdst  = ex_rd;
            n.wbsel = ex_wb_sel;
            if (bad) begin
                n.faddr = ex_alu_result;
                if (n.cnt < 255) n.cnt = n.cnt + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] = model_step(m[0], 1'b1);
        m[1] = model_step(m[1], 1'b0);
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("valid[%0d]", k), 64'(o_valid[k]), 64'(m[k].valid));
                chk($sformatf("read[%0d]", k), 64'(o_read[k]), 64'(m[k].rd));
                chk($sformatf("write[%0d]", k), 64'(o_write[k]), 64'(m[k].wr));
                chk($sformatf("werf[%0d]", k), 64'(o_werf[k]), 64'(m[k].werf));
                chk($sformatf("wefrf[%0d]", k), 64'(o_wefrf[k]), 64'(m[k].wefrf));
                chk($sformatf("pending[%0d]", k), 64'(o_pend[k]), 64'(m[k].valid && m[k].rd));
                chk($sformatf("misaligned[%0d]", k), 64'(o_misal[k]), 64'(m[k].misal));
                chk($sformatf("fault_addr[%0d]", k), 64'(o_faddr[k]), 64'(m[k].faddr));
                chk($sformatf("count[%0d]", k), 64'(o_cnt[k]), 64'(m[k].cnt));
                if (m[k].valid) begin
                    chk($sformatf("address[%0d]", k), 64'(o_addr[k]), 64'(m[k].addr));
                    chk($sformatf("alu_result[%0d]", k), 64'(o_alu[k]), 64'(m[k].addr));
                    chk($sformatf("store_data[%0d]", k), 64'(o_sdata[k]), 64'(m[k].sdata));
                    chk($sformatf("fp_result[%0d]", k), 64'(o_fp[k]), 64'(m[k].fp));
                    chk($sformatf("load_width[%0d]", k), 64'(o_lw[k]), 64'(m[k].lw));
                    chk($sformatf("store_width[%0d]", k), 64'(o_sw[k]), 64'(m[k].sw));
                    chk($sformatf("rd[%0d]", k), 64'(o_rd[k]), 64'(m[k].rdst));
                    chk($sformatf("wb_sel[%0d]", k), 64'(o_wbsel[k]), 64'(m[k].wbsel));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic acc(input bit v, input bit rd, input bit wr, input logic [2:0] w,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input bit we, input bit wfe, input logic [1:0] wb);
        ex_valid       = v;
        ex_mem_read    = rd;
        ex_mem_write   = wr;
        ex_load_width  = w;
        ex_store_width = w;
        ex_alu_result  = addr;
        ex_store_data  = sd;
        ex_fp_result   = addr ^ 32'h5A5A_0000;
        ex_rd          = addr[6:2];
        ex_werf        = we;
        ex_wefrf       = wfe;
        ex_wb_sel      = wb;
    endtask

    initial begin
        m[0] = '{default: 0};
        m[1] = '{default: 0};

        rst = 1'b1;
        tick();
        chk("reset valid", 64'(o_valid[0]), 64'd0);
        chk("reset fault_addr", 64'(o_faddr[0]), 64'd0);
        chk("reset count", 64'(o_cnt[0]), 64'd0);
        chk("reset store_data", 64'(o_sdata[0]), 64'd0);
        rst = 1'b0;

        // SW at 0x100; load width set illegal so only the store width may be used.
        acc(1, 0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 2'b00);
        ex_load_width = 3'b011;
        tick();
        chk("sw write", 64'(o_write[0]), 64'd1);
        chk("sw address", 64'(o_addr[0]), 64'h100);
        chk("sw data", 64'(o_sdata[0]), 64'hDEAD_BEEF);
        chk("sw misaligned", 64'(o_misal[0]), 64'd0);

        // LW at 0x102 is squashed; store width B must not mask it.
        acc(1, 1, 0, 3'b010, 32'h102, 32'h0, 1, 0, 2'b01);
        ex_store_width = 3'b000;
        tick();
        chk("lw102 read", 64'(o_read[0]), 64'd0);
        chk("lw102 werf", 64'(o_werf[0]), 64'd0);
        chk("lw102 misaligned", 64'(o_misal[0]), 64'd1);
        chk("lw102 fault_addr", 64'(o_faddr[0]), 64'h102);
        chk("lw102 count", 64'(o_cnt[0]), 64'd1);
        chk("lw102 nocheck read", 64'(o_read[1]), 64'd1);

        acc(1, 1, 0, 3'b001, 32'h102, 32'h0, 1, 0, 2'b01);
        tick();
        chk("lh102 misaligned", 64'(o_misal[0]), 64'd0);
        chk("lh102 read", 64'(o_read[0]), 64'd1);

        // Misaligned SH held through three stall cycles.
        acc(1, 0, 1, 3'b001, 32'h1, 32'h1234_5678, 0, 0, 2'b00);
        tick();
        chk("sh1 misaligned", 64'(o_misal[0]), 64'd1);
        chk("sh1 count", 64'(o_cnt[0]), 64'd2);
        stall = 1'b1;
        acc(1, 1, 0, 3'b010, 32'h40, 32'h0, 1, 0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall misaligned", 64'(o_misal[0]), 64'd1);
            chk("stall count", 64'(o_cnt[0]), 64'd2);
        end
        stall = 1'b0;
        tick();
        chk("post-stall misaligned", 64'(o_misal[0]), 64'd0);
        chk("post-stall read", 64'(o_read[0]), 64'd1);

        // Flush wins over stall.
        stall = 1'b1;
        flush = 1'b1;
        acc(1, 1, 0, 3'b010, 32'h80, 32'h0, 1, 0, 2'b01);
        tick();
        chk("flush+stall valid", 64'(o_valid[0]), 64'd0);
        chk("flush+stall read", 64'(o_read[0]), 64'd0);
        chk("flush+stall pending", 64'(o_pend[0]), 64'd0);
        stall = 1'b0;

        // Flush with a misaligned access records nothing.
        acc(1, 1, 0, 3'b010, 32'h81, 32'h0, 1, 0, 2'b01);
        tick();
        chk("flush misal count", 64'(o_cnt[0]), 64'd2);
        chk("flush misal fault_addr", 64'(o_faddr[0]), 64'h1);
        flush = 1'b0;

        // Read and write together behave as a store.
        acc(1, 1, 1, 3'b010, 32'h200, 32'hCAFE_F00D, 0, 0, 2'b00);
        tick();
        chk("rw write", 64'(o_write[0]), 64'd1);
        chk("rw read", 64'(o_read[0]), 64'd0);

        // Illegal width encoding, bubble with misaligned address, byte/half variants.
        acc(1, 1, 0, 3'b011, 32'h300, 32'h0, 0, 1, 2'b10);
        tick();
        chk("illegal width misaligned", 64'(o_misal[0]), 64'd1);
        chk("illegal width count", 64'(o_cnt[0]), 64'd3);
        acc(0, 1, 0, 3'b010, 32'h7, 32'h0, 1, 0, 2'b01);
        tick();
        chk("bubble valid", 64'(o_valid[0]), 64'd0);
        chk("bubble count", 64'(o_cnt[0]), 64'd3);
        acc(1, 1, 0, 3'b100, 32'h7, 32'h0, 1, 0, 2'b01);
        tick();
        acc(1, 1, 0, 3'b101, 32'h6, 32'h0, 0, 1, 2'b10);
        tick();
        chk("lhu6 read", 64'(o_read[0]), 64'd1);
        acc(1, 1, 0, 3'b101, 32'h5, 32'h0, 1, 0, 2'b01);
        tick();
        chk("lhu5 count", 64'(o_cnt[0]), 64'd4);
        acc(1, 0, 0, 3'b011, 32'h3, 32'h0, 1, 0, 2'b11);
        tick();
        chk("no access misaligned", 64'(o_misal[0]), 64'd0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            acc(1, 1, 0, 3'b010, 32'h1000 + 32'(i) * 4 + 3, 32'h0, 1, 0, 2'b01);
            tick();
        end
        chk("saturated count", 64'(o_cnt[0]), 64'd255);
        chk("saturated fault_addr", 64'(o_faddr[0]), 64'h1000 + 299 * 4 + 3);
        chk("nocheck count", 64'(o_cnt[1]), 64'd0);
        chk("nocheck lw3 read", 64'(o_read[1]), 64'd1);

        // Reset during a stall clears everything.
        stall = 1'b1;
        acc(1, 1, 0, 3'b010, 32'h20, 32'h0, 1, 0, 2'b01);
        tick();
        rst = 1'b1;
        tick();
        chk("rst-stall valid", 64'(o_valid[0]), 64'd0);
        chk("rst-stall count", 64'(o_cnt[0]), 64'd0);
        chk("rst-stall fault_addr", 64'(o_faddr[0]), 64'd0);
        chk("rst-stall misaligned", 64'(o_misal[0]), 64'd0);
        chk("rst-stall address", 64'(o_addr[0]), 64'd0);
        rst = 1'b0;
        stall = 1'b0;
        acc(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 2'b00);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
